// File: rtl/muldiv_unit.sv
// Iterative unsigned 32-bit MUL/MULHU/DIVU/REMU feeding the register file write port.
// 33 cycles from accept to write-back (1 when dividing by zero); start is ignored while busy.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [4:0]  dest,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  dest_q;
  logic [5:0]  cnt_q;
  logic [31:0] a_q;
  logic [63:0] acc_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;

  logic        div_zero;
  logic        last_iter;
  logic [32:0] mul_sum;
  logic [63:0] acc_nxt;
  logic [32:0] rem_shift;
  logic [33:0] rem_diff;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] result_nxt;

  assign div_zero  = op[1] && (src1 == 32'd0);
  assign last_iter = (cnt_q == 6'd31);

  // a_q is the multiplicand for MUL/MULHU and the divisor for DIVU/REMU.
  always_comb begin
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    acc_nxt    = {mul_sum, acc_q[31:1]};
    rem_shift  = {rem_q[31:0], quo_q[31]};
    rem_diff   = {1'b0, rem_shift} - {2'b00, a_q};
    rem_nxt    = rem_diff[33] ? rem_shift : rem_diff[32:0];
    quo_nxt    = {quo_q[30:0], ~rem_diff[33]};
    result_nxt = acc_nxt[31:0];
    case (op_q)
      OP_MUL:   result_nxt = acc_nxt[31:0];
      OP_MULHU: result_nxt = acc_nxt[63:32];
      OP_DIVU:  result_nxt = quo_nxt;
      OP_REMU:  result_nxt = rem_nxt[31:0];
      default:  result_nxt = acc_nxt[31:0];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = div_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        we      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= 2'd0;
      dest_q <= 5'd0;
      cnt_q  <= 6'd0;
      a_q    <= 32'd0;
      acc_q  <= 64'd0;
      rem_q  <= 33'd0;
      quo_q  <= 32'd0;
      wa     <= 5'd0;
      wd     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest;
            cnt_q  <= 6'd0;
            a_q    <= op[1] ? src1 : src0;
            acc_q  <= {32'd0, src1};
            rem_q  <= 33'd0;
            quo_q  <= src0;
            // Divide by zero skips RUN, so the write-back is staged here.
            if (div_zero) begin
              wa <= dest;
              wd <= op[0] ? src0 : 32'hFFFF_FFFF;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 6'd1;
          acc_q <= acc_nxt;
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (last_iter) begin
            wa <= dest_q;
            wd <= result_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
